// File: rtl/axis_width_conv_wide_narrow.sv
// Wide-to-narrow stream splitter: each M-bit word leaves as M/N beats of N bits, MSB slice first.
// The pop strobe to the upstream FWFT FIFO is combinational so the word boundary costs no bubble.
module axis_width_conv_wide_narrow #(
    parameter int N = 8,
    parameter int M = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] s_axis_tdata,
    input  logic         s_axis_tfirst,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tnext,
    output logic [N-1:0] m_axis_tdata,
    output logic         m_axis_tfirst,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tnext
);
    // state | meaning
    // EMPTY | full=0, nothing held, next source word loads immediately
    // BUSY  | full=1, cnt<K-1, shifting out beats of the held word
    // LAST  | full=1, cnt==K-1, final beat shown; a new word may load on its transfer

    localparam int K  = M / N;
    localparam int CW = ($clog2(K) < 1) ? 1 : $clog2(K);
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    if ((N < 1) || (M <= N) || ((M % N) != 0)) begin : g_param_check
        $fatal(1, "axis_width_conv_wide_narrow: M must be a multiple of N and larger than N");
    end

    logic [M-1:0]  shreg;
    logic          first;
    logic [CW-1:0] cnt;
    logic          full;
    logic          last_beat;
    logic          load;
    logic          m_xfer;

    assign last_beat = (cnt == CNT_LAST);
    assign load      = ~full | (last_beat & m_axis_tnext);
    assign m_xfer    = full & m_axis_tnext;

    assign s_axis_tnext  = s_axis_tvalid & load & ~rst;
    assign m_axis_tdata  = shreg[M-1 -: N];
    assign m_axis_tfirst = first & (cnt == '0);
    assign m_axis_tvalid = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            first <= 1'b0;
            cnt   <= '0;
            full  <= 1'b0;
        end else if (s_axis_tnext) begin
            shreg <= s_axis_tdata;
            first <= s_axis_tfirst;
            cnt   <= '0;
            full  <= 1'b1;
        end else if (m_xfer) begin
            if (last_beat) begin
                // Clearing the idle state keeps tdata/tfirst at zero while nothing is valid.
                shreg <= '0;
                first <= 1'b0;
                cnt   <= '0;
                full  <= 1'b0;
            end else begin
                shreg <= {shreg[M-N-1:0], {N{1'b0}}};
                cnt   <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_axis_width_conv_wide_narrow.sv
// Self-checking bench for axis_width_conv_wide_narrow (N=8, M=24): vector table, hand sequences,
// and a randomized backpressure run against a queue-based split model.
module tb_axis_width_conv_wide_narrow;
    localparam int N  = 8;
    localparam int M  = 24;
    localparam int K  = M / N;
    localparam int NW = 2048;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] s_tdata;
    logic         s_tfirst;
    logic         s_tvalid;
    logic         s_tnext;
    logic [N-1:0] m_tdata;
    logic         m_tfirst;
    logic         m_tvalid;
    logic         m_tnext;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_width_conv_wide_narrow #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tfirst(s_tfirst),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tnext (s_tnext),
        .m_axis_tdata (m_tdata),
        .m_axis_tfirst(m_tfirst),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tnext (m_tnext)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [M-1:0] word;
        logic         first;
        logic [N-1:0] b0;
        logic [N-1:0] b1;
        logic [N-1:0] b2;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] d;
        logic         f;
        logic         last;
    } beat_t;

    vec_t  vt[4];
    beat_t q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_b;
        logic [M-1:0] w3[3];
        logic         f3[3];
        logic [N-1:0] prev_d;
        logic         prev_f;
        logic         prev_stall;
        logic         popped;
        logic         exp_sn;
        logic         front_last;
        int           sent;
        int           cyc;
        int           idx;
        int           pops;

        vt[0] = '{24'hA1B2C3, 1'b1, 8'hA1, 8'hB2, 8'hC3};
        vt[1] = '{24'h00FF00, 1'b0, 8'h00, 8'hFF, 8'h00};
        vt[2] = '{24'h123456, 1'b1, 8'h12, 8'h34, 8'h56};
        vt[3] = '{24'hFFFFFF, 1'b0, 8'hFF, 8'hFF, 8'hFF};

        // Reset state, with a word offered to prove the pop strobe is gated by reset.
        rst = 1'b1; s_tdata = 24'h5A5A5A; s_tfirst = 1'b1; s_tvalid = 1'b1; m_tnext = 1'b0;
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tfirst", m_tfirst, 0);
        chk("rst_snext", s_tnext, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; s_tvalid = 1'b0; s_tfirst = 1'b0;

        // Table: one isolated word at a time, sink always ready.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1; s_tdata = vt[i].word; s_tfirst = vt[i].first; m_tnext = 1'b0;
            @(negedge clk);
            chk("tbl_idle_valid", m_tvalid, 0);
            chk("tbl_pop", s_tnext, 1);
            @(posedge clk); #1;
            s_tvalid = 1'b0; m_tnext = 1'b1;
            pops = 0;
            for (int b = 0; b < K; b++) begin
                @(negedge clk);
                exp_b = (b == 0) ? vt[i].b0 : (b == 1) ? vt[i].b1 : vt[i].b2;
                chk("tbl_valid", m_tvalid, 1);
                chk("tbl_data", m_tdata, exp_b);
                chk("tbl_first", m_tfirst, (b == 0) ? vt[i].first : 1'b0);
                if (s_tnext) pops++;
                @(posedge clk); #1;
            end
            m_tnext = 1'b0;
            @(negedge clk);
            chk("tbl_pop_count", pops, 0);
            chk("tbl_empty_after", m_tvalid, 0);
        end

        // Back-to-back words: no gaps, pops coincide with the 03 and 06 transfers.
        w3[0] = 24'h010203; w3[1] = 24'h040506; w3[2] = 24'h070809;
        f3[0] = 1'b1;       f3[1] = 1'b0;       f3[2] = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = w3[0]; s_tfirst = f3[0]; m_tnext = 1'b1;
        @(negedge clk);
        chk("b2b_load", s_tnext, 1);
        @(posedge clk); #1;
        idx = 1; s_tdata = w3[1]; s_tfirst = f3[1];
        for (int b = 0; b < 9; b++) begin
            @(negedge clk);
            chk("b2b_valid", m_tvalid, 1);
            chk("b2b_data", m_tdata, b + 1);
            chk("b2b_first", m_tfirst, (b == 0 || b == 6) ? 1'b1 : 1'b0);
            chk("b2b_snext", s_tnext, (b == 2 || b == 5) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
            if (b == 2 || b == 5) begin
                idx++;
                if (idx < 3) begin
                    s_tdata = w3[idx]; s_tfirst = f3[idx];
                end else begin
                    s_tvalid = 1'b0; s_tfirst = 1'b0;
                end
            end
        end
        m_tnext = 1'b0;
        @(negedge clk);
        chk("b2b_empty_after", m_tvalid, 0);

        // Stall in LAST: pop must wait for the final beat's transfer.
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = 24'hA1B2C3; s_tfirst = 1'b0; m_tnext = 1'b1;
        @(posedge clk); #1;
        s_tdata = 24'h445566;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_tnext = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_last_data", m_tdata, 8'hC3);
            chk("stall_last_snext", s_tnext, 0);
            @(posedge clk); #1;
        end
        m_tnext = 1'b1;
        @(negedge clk);
        chk("stall_release_snext", s_tnext, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("stall_next_word", m_tdata, 8'h44);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_tnext = 1'b0;
        @(negedge clk);
        chk("stall_drained", m_tvalid, 0);

        // Reset mid-word after B2 transfers; the pending C3 must never appear.
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = 24'hA1B2C3; s_tfirst = 1'b1; m_tnext = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tfirst = 1'b0;
        @(negedge clk);
        chk("rmw_a1", m_tdata, 8'hA1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmw_b2", m_tdata, 8'hB2);
        @(posedge clk); #1;
        rst = 1'b1; s_tvalid = 1'b1; s_tdata = 24'hDDEEFF;
        #1;
        chk("rmw_rst_valid", m_tvalid, 0);
        chk("rmw_rst_data", m_tdata, 0);
        chk("rmw_rst_first", m_tfirst, 0);
        chk("rmw_rst_snext", s_tnext, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmw_reload", s_tnext, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        for (int b = 0; b < K; b++) begin
            @(negedge clk);
            exp_b = (b == 0) ? 8'hDD : (b == 1) ? 8'hEE : 8'hFF;
            chk("rmw_valid", m_tvalid, 1);
            chk("rmw_data", m_tdata, exp_b);
            @(posedge clk); #1;
        end
        m_tnext = 1'b0;
        @(negedge clk);
        chk("rmw_empty", m_tvalid, 0);

        // Randomized source gaps and 50% sink backpressure against a split model.
        sent = 0; cyc = 0; popped = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_f = 1'b0;
        q.delete();
        while ((sent < NW || q.size() != 0) && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            if (!s_tvalid || popped) begin
                if (sent < NW && ($urandom % 4) != 0) begin
                    s_tvalid = 1'b1;
                    s_tdata  = M'($urandom);
                    s_tfirst = (($urandom % 8) == 0);
                end else begin
                    s_tvalid = 1'b0; s_tfirst = 1'b0;
                end
            end
            m_tnext = m_tvalid && ($urandom % 2);
            @(negedge clk);
            chk("rnd_valid", m_tvalid, (q.size() != 0));
            if (prev_stall) begin
                chk("rnd_hold_data", m_tdata, prev_d);
                chk("rnd_hold_first", m_tfirst, prev_f);
            end
            front_last = (q.size() != 0) ? q[0].last : 1'b0;
            exp_sn = s_tvalid && ((q.size() == 0) || (front_last && m_tnext));
            chk("rnd_snext", s_tnext, exp_sn);
            if (m_tvalid && m_tnext && q.size() != 0) begin
                chk("rnd_data", m_tdata, q[0].d);
                chk("rnd_first", m_tfirst, q[0].f);
                void'(q.pop_front());
            end
            popped = s_tvalid && s_tnext;
            if (popped) begin
                for (int i = 0; i < K; i++)
                    q.push_back('{d: N'(s_tdata >> (N * (K - 1 - i))),
                                  f: s_tfirst && (i == 0),
                                  last: (i == K - 1)});
                sent++;
            end
            prev_stall = m_tvalid && !m_tnext;
            prev_d = m_tdata;
            prev_f = m_tfirst;
        end
        if (cyc >= 40000) chk("rnd_timeout", 1, 0);
        s_tvalid = 1'b0;
        m_tnext  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
